pic_interrupt_sequencer: RTL
============================

// Module: pic_interrupt_sequencer
// PURPOSE
//  Control/sequencing core of the 8259A-style PIC: resolves the highest-priority unmasked request against
//  the In-Service Register, raises INT, runs the two-pulse INTA handshake, and sets/clears ISR and IRR bits.
//  Drives the interrupt vector and handles EOI commands, AEOI mode and priority rotation.
//  Sits between the IRR/IMR registers and the CPU-side bus/control logic.
// PARAMETERS
//  NUM_IR   8   number of interrupt levels (fixed at 8; level index is 3 bits)
// PORTS
//  CLK          in   1  system clock, all logic on rising edge
//  RESET        in   1  synchronous, active-high reset
//  IRR          in   8  pending requests from IRR
//  IMR          in   8  mask; 1 = level masked
//  INTA         in   1  active-high acknowledge level, already synchronised to CLK
//  ICW2_VEC     in   5  vector base T7..T3
//  AEOI         in   1  1 = automatic EOI at end of 2nd INTA
//  AEOI_ROTATE  in   1  1 = rotate priority on automatic EOI
//  EOI_CMD      in   1  one-cycle pulse: execute EOI command
//  EOI_SPECIFIC in   1  1 = specific EOI on EOI_LEVEL, 0 = non-specific
//  EOI_ROTATE   in   1  1 = rotate priority with this EOI
//  EOI_LEVEL    in   3  level for specific EOI
//  INT          out  1  interrupt request to CPU
//  IRR_CLR      out  8  one-hot, one-cycle pulse clearing acknowledged IRR bit
//  ISR          out  8  In-Service Register
//  VEC          out  8  {ICW2_VEC, level}, valid while VEC_OE=1
//  VEC_OE       out  1  data bus drive enable for vector
//  PRIO_BASE    out  3  current lowest-priority level (priority order starts at PRIO_BASE+1 mod 8)
// BEHAVIOUR
//  Reset: INT=0, IRR_CLR=0, ISR=0, VEC=0, VEC_OE=0, PRIO_BASE=7 (IR0 highest), state=IDLE.
//  Requests: REQ = IRR & ~IMR. Winner = first set bit scanning (PRIO_BASE+1)%8 upward, wrapping mod 8.
//  Eligible only if winner is strictly higher priority than highest-priority set ISR bit (fully nested);
//   ISR=0 -> any winner eligible. All priority compares use rotated order.
//  INTA edges: registered INTA_q; rise = INTA & ~INTA_q, fall = ~INTA & INTA_q.
//  FSM:
//   IDLE  : eligible winner -> REQ, INT=1 next cycle.
//   REQ   : INT=1. On rise: INT=0; if REQ still has eligible winner -> LVL<=winner, ISR[winner]<=1,
//           IRR_CLR=onehot(winner) for exactly that cycle+1; else spurious: LVL<=7, no ISR/IRR change.
//           -> ACK1.  REQ dropping before rise keeps INT=1 (spurious handled at rise).
//   ACK1  : on fall -> WAIT2.
//   WAIT2 : on rise -> VEC<={ICW2_VEC,LVL}, VEC_OE=1 -> ACK2.
//   ACK2  : VEC_OE held 1. On fall: VEC_OE=0; if AEOI and not spurious: ISR[LVL]<=0,
//           AEOI_ROTATE -> PRIO_BASE<=LVL. -> IDLE.
//  INT is never re-raised before returning to IDLE; earliest re-raise 1 cycle after ACK2 fall.
//  EOI (accepted in any state, on EOI_CMD=1):
//   non-specific: clear highest-priority set ISR bit L; EOI_ROTATE -> PRIO_BASE<=L. ISR=0 -> no-op, no rotate.
//   specific: clear ISR[EOI_LEVEL] (even if already 0); EOI_ROTATE -> PRIO_BASE<=EOI_LEVEL.
//  Simultaneous EOI and ISR set (REQ rise): EOI evaluated on pre-set ISR; new bit set wins if same level.
//  Simultaneous EOI rotate and AEOI rotate: EOI_CMD value of PRIO_BASE wins.
//  Winner/eligibility is combinational from current ISR/PRIO_BASE; registered decisions take effect next cycle.
//  RESET mid-handshake: returns to reset values next cycle; no IRR_CLR issued.
//  Latency: IDLE->INT 1 cycle; INTA rise->IRR_CLR/ISR 1 cycle; 2nd rise->VEC_OE 1 cycle.
// CONFIGURATION
//  PIC_ROTATE_EN defined: rotation via EOI_ROTATE/AEOI_ROTATE as above.
//  PIC_ROTATE_EN undefined: PRIO_BASE constant 7 (fixed priority IR0 highest), EOI_ROTATE/AEOI_ROTATE ignored;
//   all other behaviour identical.
// TESTING
//  1 Fixed prio: IRR=8'h30, IMR=0, ICW2_VEC=5'h08 -> INT=1; 1st INTA -> IRR_CLR=8'h10, ISR=8'h10;
//    2nd INTA -> VEC=8'h44, VEC_OE=1 until fall.
//  2 Nesting: ISR=8'h10, IRR=8'h20 -> INT stays 0; IRR=8'h04 -> INT=1, ack gives ISR=8'h14.
//  3 Spurious: INT=1 for IR3, IRR->0 before INTA -> no IRR_CLR, ISR unchanged, VEC={ICW2_VEC,3'd7}.
//  4 AEOI+AEOI_ROTATE, IRR=8'h01 -> after 2nd INTA fall ISR=0, PRIO_BASE=0; then IRR=8'h03 -> IR1 wins.
//  5 Non-specific EOI+rotate with ISR=8'h28 -> ISR=8'h20, PRIO_BASE=3; EOI with ISR=0 -> no change.
//  6 RESET asserted in WAIT2 -> next cycle INT=0, VEC_OE=0, ISR=0, PRIO_BASE=7; repeat 4 with macro off -> PRIO_BASE stays 7.

Source files
------------

// File: rtl/pic_interrupt_sequencer.sv
// 8259A-style interrupt sequencer: priority resolve, INT/INTA handshake, ISR/IRR control, EOI and rotation.
// Define PIC_ROTATE_EN to enable priority rotation; otherwise priority is fixed with IR0 highest.
module pic_interrupt_sequencer #(
  parameter int NUM_IR = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_IR-1:0] IRR,
  input  logic [NUM_IR-1:0] IMR,
  input  logic              INTA,
  input  logic [4:0]        ICW2_VEC,
  input  logic              AEOI,
  input  logic              AEOI_ROTATE,
  input  logic              EOI_CMD,
  input  logic              EOI_SPECIFIC,
  input  logic              EOI_ROTATE,
  input  logic [2:0]        EOI_LEVEL,
  output logic              INT,
  output logic [NUM_IR-1:0] IRR_CLR,
  output logic [NUM_IR-1:0] ISR,
  output logic [7:0]        VEC,
  output logic              VEC_OE,
  output logic [2:0]        PRIO_BASE
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK1, S_WAIT2, S_ACK2} state_t;

  state_t            state_q, state_d;
  logic              inta_q;
  logic              int_q, int_d;
  logic [NUM_IR-1:0] irr_clr_q, irr_clr_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [2:0]        lvl_q, lvl_d;
  logic              spur_q, spur_d;
  logic [7:0]        vec_q, vec_d;
  logic              vec_oe_q, vec_oe_d;
  logic [2:0]        prio_q, prio_d;

  logic              inta_rise, inta_fall;
  logic              eoi_rot, aeoi_rot;

`ifdef PIC_ROTATE_EN
  assign eoi_rot  = EOI_ROTATE;
  assign aeoi_rot = AEOI_ROTATE;
`else
  // prio_q never leaves its reset value 7, so priority stays fixed
  logic unused_rot;
  assign eoi_rot    = 1'b0;
  assign aeoi_rot   = 1'b0;
  assign unused_rot = ^{EOI_ROTATE, AEOI_ROTATE};
`endif

  assign inta_rise = INTA & ~inta_q;
  assign inta_fall = ~INTA & inta_q;

  // Rank 0 is the level just above PRIO_BASE; both scans share the rotated order
  logic [NUM_IR-1:0] req;
  logic [2:0]        idx;
  logic              win_found, top_found, eligible;
  logic [2:0]        win_lvl, win_rank, top_lvl, top_rank;
  logic [NUM_IR-1:0] win_oh, top_oh, lvl_oh;

  always_comb begin
    req       = IRR & ~IMR;
    idx       = '0;
    win_found = 1'b0;
    win_lvl   = '0;
    win_rank  = '0;
    top_found = 1'b0;
    top_lvl   = '0;
    top_rank  = '0;
    for (int i = 0; i < NUM_IR; i++) begin
      idx = prio_q + 3'(i) + 3'd1;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_lvl   = idx;
        win_rank  = 3'(i);
      end
      if (!top_found && isr_q[idx]) begin
        top_found = 1'b1;
        top_lvl   = idx;
        top_rank  = 3'(i);
      end
    end
    eligible = win_found && (!top_found || (win_rank < top_rank));
  end

  assign win_oh = {{(NUM_IR-1){1'b0}}, 1'b1} << win_lvl;
  assign top_oh = {{(NUM_IR-1){1'b0}}, 1'b1} << top_lvl;
  assign lvl_oh = {{(NUM_IR-1){1'b0}}, 1'b1} << lvl_q;

  logic [NUM_IR-1:0] isr_set, aeoi_clr, eoi_clr;

  always_comb begin
    state_d   = state_q;
    int_d     = int_q;
    irr_clr_d = '0;
    lvl_d     = lvl_q;
    spur_d    = spur_q;
    vec_d     = vec_q;
    vec_oe_d  = vec_oe_q;
    prio_d    = prio_q;
    isr_set   = '0;
    aeoi_clr  = '0;
    eoi_clr   = '0;

    case (state_q)
      S_IDLE: begin
        if (eligible) begin
          state_d = S_REQ;
          int_d   = 1'b1;
        end
      end
      S_REQ: begin
        if (inta_rise) begin
          int_d   = 1'b0;
          state_d = S_ACK1;
          if (eligible) begin
            lvl_d     = win_lvl;
            spur_d    = 1'b0;
            isr_set   = win_oh;
            irr_clr_d = win_oh;
          end else begin
            lvl_d  = 3'd7;
            spur_d = 1'b1;
          end
        end
      end
      S_ACK1: begin
        if (inta_fall) state_d = S_WAIT2;
      end
      S_WAIT2: begin
        if (inta_rise) begin
          vec_d    = {ICW2_VEC, lvl_q};
          vec_oe_d = 1'b1;
          state_d  = S_ACK2;
        end
      end
      S_ACK2: begin
        if (inta_fall) begin
          vec_oe_d = 1'b0;
          state_d  = S_IDLE;
          if (AEOI && !spur_q) begin
            aeoi_clr = lvl_oh;
            if (aeoi_rot) prio_d = lvl_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // EOI sees the pre-update ISR and its rotation overrides an AEOI rotation
    if (EOI_CMD) begin
      if (EOI_SPECIFIC) begin
        eoi_clr = {{(NUM_IR-1){1'b0}}, 1'b1} << EOI_LEVEL;
        if (eoi_rot) prio_d = EOI_LEVEL;
      end else if (top_found) begin
        eoi_clr = top_oh;
        if (eoi_rot) prio_d = top_lvl;
      end
    end

    isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | isr_set;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      inta_q    <= 1'b0;
      int_q     <= 1'b0;
      irr_clr_q <= '0;
      isr_q     <= '0;
      lvl_q     <= '0;
      spur_q    <= 1'b0;
      vec_q     <= '0;
      vec_oe_q  <= 1'b0;
      prio_q    <= 3'd7;
    end else begin
      state_q   <= state_d;
      inta_q    <= INTA;
      int_q     <= int_d;
      irr_clr_q <= irr_clr_d;
      isr_q     <= isr_d;
      lvl_q     <= lvl_d;
      spur_q    <= spur_d;
      vec_q     <= vec_d;
      vec_oe_q  <= vec_oe_d;
      prio_q    <= prio_d;
    end
  end

  assign INT       = int_q;
  assign IRR_CLR   = irr_clr_q;
  assign ISR       = isr_q;
  assign VEC       = vec_q;
  assign VEC_OE    = vec_oe_q;
  assign PRIO_BASE = prio_q;

endmodule
